elastic_data_pipeline: RTL
==========================

Name: elastic_data_pipeline

Overview:
Parametrised successor to the plain shift-register delay line. It adds a per-stage valid bit, valid/ready backpressure, bubble collapsing, a synchronous flush and an occupancy count. It sits between datapath stages of the Ethernet receive path, for example between the byte assembler and the frame parser. Use it wherever register slices must respect downstream stalls without losing or duplicating beats.

Parameters:
DATA_W, 32, payload width in bits.
PIPE_DEPTH, 1, number of register stages; 0 gives a combinational pass-through.
RESET_EN, 1, when 1 the stage data registers also reset to RESET_VALUE; valid bits always reset.
RESET_VALUE, 0, data reset value, truncated/zero-extended to DATA_W.
CNT_W, $clog2(PIPE_DEPTH+1), width of count_o (derived; not for override).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
flush_i  input  1  synchronous clear of all held beats.
valid_i  input  1  upstream beat valid.
ready_o  output  1  block can accept a beat this cycle.
data_i  input  DATA_W  upstream payload.
valid_o  output  1  output stage holds a beat.
ready_i  input  1  downstream accepts the output beat.
data_o  output  DATA_W  output payload.
count_o  output  CNT_W  number of valid stages.

Behaviour:
- Stages are 0..N-1 (N = PIPE_DEPTH). Each stage has v[i] and d[i]. Stage N-1 drives the outputs: valid_o = v[N-1], data_o = d[N-1].
- Pop and accept terms (combinational chain from ready_i, with no registered ready):
  - pop[N-1] = ready_i.
  - pop[i] = acc[i+1].
  - acc[i] = !v[i] || pop[i].
- ready_o = acc[0] && !flush_i.
- Input transfer occurs when valid_i && ready_o. Output transfer occurs when valid_o && ready_i.
- On each clk edge, for each stage with acc[i]=1:
  - v[i] <= incoming valid (valid_i && !flush_i for stage 0; v[i-1] otherwise).
  - d[i] loads the incoming data only when the incoming valid is 1; otherwise d[i] holds.
- A stage with acc[i]=0 holds both v[i] and d[i]. data_o is therefore stable while valid_o && !ready_i.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Latency with no stalls is N cycles from input transfer to valid_o. Throughput is one beat per cycle with ready_i held high.
- Full condition: all v=1 and ready_i=0 gives ready_o=0. Simultaneous pop and push when full gives ready_o=1, with no bubble and no loss.
- Flush: while flush_i=1, ready_o=0. An output transfer in the flush cycle still counts as consumed. At the next edge all v[i] <= 0, and d holds. Flush takes priority over every other event.
- count_o is a registered count of set v bits, updated every edge with:
  - +1 on input transfer.
  - -1 on output transfer.
  - 0 after flush.
  - Range 0..N, never wraps.
- Reset (rst_n=0, asynchronous): all v=0, valid_o=0, count_o=0. d = RESET_VALUE if RESET_EN, otherwise d is unreset. ready_o=1 (when N>=1) as soon as reset deasserts. Reset mid-stream discards every held beat.
- PIPE_DEPTH=0: valid_o=valid_i, data_o=data_i, ready_o=ready_i && !flush_i. valid_o is also gated by !flush_i. count_o=0 and no registers are present.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped, except by flush or reset.

Test Plan:
1. N=3, stream 0x01..0x08 with ready_i=1 → valid_o first high 3 cycles after the first transfer; 0x01..0x08 emerge back-to-back; count_o peaks at 3.
2. N=3, ready_i=0 while pushing 0xA,0xB,0xC,0xD → 0xA-0xC accepted, ready_o=0 on 0xD; data_o holds 0xA; count_o=3; raising ready_i delivers 0xA,0xB,0xC,0xD in order.
3. N=3 full, ready_i=1 and valid_i=1 simultaneously for 5 cycles → ready_o stays 1, count_o stays 3, no gaps on output.
4. N=4, two beats 0x11,0x22 separated by 2 idle cycles, ready_i=0 → bubbles collapse, count_o=2, both beats adjacent when released.
5. N=3 holding 2 beats, flush_i=1 with valid_i=1 → ready_o=0 that cycle; next cycle valid_o=0 and count_o=0; the input beat is not captured.
6. Assert rst_n=0 asynchronously mid-stream (between edges) → valid_o=0 and count_o=0 immediately; data_o=RESET_VALUE (0x0) with RESET_EN=1; PIPE_DEPTH=0 variant passes 0x5A combinationally.

Source files
------------

// File: rtl/elastic_data_pipeline.sv
// Elastic register pipeline: per-stage valid bits, valid/ready backpressure
// with bubble collapsing, synchronous flush and a registered occupancy count.
// PIPE_DEPTH=0 degenerates to a combinational pass-through with no state.
module elastic_data_pipeline #(
  parameter int                DATA_W      = 32,
  parameter int                PIPE_DEPTH  = 1,
  parameter bit                RESET_EN    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter int                CNT_W       = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [DATA_W-1:0]                 data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [DATA_W-1:0]                 data_o,
  output logic [((CNT_W > 0) ? CNT_W : 1)-1:0] count_o
);

  // count_o keeps at least one bit so the depth-0 build still has a legal port
  localparam int CNT_PW = (CNT_W > 0) ? CNT_W : 1;

  generate
    if (PIPE_DEPTH == 0) begin : g_bypass
      logic w_unused_ok;

      assign valid_o     = valid_i && !flush_i;
      assign data_o      = data_i;
      assign ready_o     = ready_i && !flush_i;
      assign count_o     = '0;
      assign w_unused_ok = &{1'b0, clk, rst_n};
    end else begin : g_pipe
      localparam int N = PIPE_DEPTH;

      logic [N-1:0]      r_v;
      logic [DATA_W-1:0] r_d [N];
      logic [CNT_PW-1:0] r_cnt;
      logic [N-1:0]      w_acc;
      logic [N-1:0]      w_vin;
      logic [N-1:0]      w_load;
      logic              w_in_xfer;
      logic              w_out_xfer;

      // Accept chain from the output backwards: a stage accepts when empty or
      // when the stage ahead of it accepts (ready_i for the last stage).
      always_comb begin
        logic w_chain;
        w_acc   = '0;
        w_chain = ready_i;
        for (int i = N - 1; i >= 0; i--) begin
          w_acc[i] = !r_v[i] || w_chain;
          w_chain  = w_acc[i];
        end
      end

      // Valid presented to each stage: upstream for stage 0, predecessor otherwise
      always_comb begin
        w_vin    = '0;
        w_vin[0] = valid_i && !flush_i;
        for (int i = 1; i < N; i++) begin
          w_vin[i] = r_v[i-1];
        end
      end

      assign w_load     = w_acc & w_vin & {N{!flush_i}};
      assign ready_o    = w_acc[0] && !flush_i;
      assign valid_o    = r_v[N-1];
      assign data_o     = r_d[N-1];
      assign count_o    = r_cnt;
      assign w_in_xfer  = valid_i && ready_o;
      assign w_out_xfer = r_v[N-1] && ready_i;

      // Valid bits: flush clears everything, accepting stages take the incoming valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= '0;
        end else if (flush_i) begin
          r_v <= '0;
        end else begin
          r_v <= (w_acc & w_vin) | (~w_acc & r_v);
        end
      end

      if (RESET_EN) begin : g_d_rst
        // Data registers with reset: load only when a real beat moves in
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
              r_d[i] <= RESET_VALUE;
            end
          end else begin
            if (w_load[0]) begin
              r_d[0] <= data_i;
            end
            for (int i = 1; i < N; i++) begin
              if (w_load[i]) begin
                r_d[i] <= r_d[i-1];
              end
            end
          end
        end
      end else begin : g_d_nrst
        // Data registers without reset: load only when a real beat moves in
        always_ff @(posedge clk) begin
          if (w_load[0]) begin
            r_d[0] <= data_i;
          end
          for (int i = 1; i < N; i++) begin
            if (w_load[i]) begin
              r_d[i] <= r_d[i-1];
            end
          end
        end
      end

      // Occupancy: +1 per input transfer, -1 per output transfer, zero on flush
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (flush_i) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_PW'(w_in_xfer) - CNT_PW'(w_out_xfer);
        end
      end
    end
  endgenerate

endmodule
